// File: rtl/aurora_clk_pkg.sv
// Shared clocking definitions for the Aurora wrappers: sequencer state
// encoding, a constant clog2 helper and the default MMCM bring-up timing.
package aurora_clk_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_PULSE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STABLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_FLT    = 3'd5
  } seq_state_e;

  localparam int DEF_NCHAN         = 1;
  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 65535;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 7;
  localparam int DEF_CNT_W         = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchroniser for quasi-static level signals; each bit is
// synchronised independently, so only use it for flags, never for buses.
module cdc_sync_bit #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta_q;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mmcm_lock_sequencer.sv
// MMCM reset/lock sequencer: holds the MMCM in reset until every transceiver
// PLL is locked, then waits for a debounced MMCM lock with timeout and retry.
module mmcm_lock_sequencer
  import aurora_clk_pkg::*;
#(
  parameter int NCHAN         = DEF_NCHAN,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W,
  localparam int RC_W = (clog2(MAX_RETRIES + 1) < 1) ? 1 : clog2(MAX_RETRIES + 1)
) (
  input  logic             INIT_CLK,
  input  logic             RESET,
  input  logic [NCHAN-1:0] TX_LOCKED,
  input  logic             MMCM_LOCKED,
  input  logic             RETRY_CLR,
  output logic             MMCM_RESET,
  output logic             MMCM_NOT_LOCKED,
  output logic             READY,
  output logic             FAULT,
  output logic [RC_W-1:0]  RETRY_COUNT,
  output logic [CNT_W-1:0] LOSS_COUNT,
  output logic [2:0]       STATE
);

  localparam int TMAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CW   = (clog2(TMAX) < 1) ? 1 : clog2(TMAX);

  localparam logic [CW-1:0]   RST_LOAD     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]   TIMEOUT_LOAD = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]   STABLE_LOAD  = CW'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0] RETRY_LAST   = RC_W'(MAX_RETRIES);

  logic [NCHAN-1:0] tx_sync;
  logic             lock_sync;
  logic             tx_ok;

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RC_W-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             count_loss;
  logic             mmcm_reset_q, mmcm_reset_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  cdc_sync_bit #(.WIDTH(NCHAN)) u_tx_sync (
    .clk_i (INIT_CLK),
    .rst_i (RESET),
    .d_i   (TX_LOCKED),
    .q_o   (tx_sync)
  );

  cdc_sync_bit #(.WIDTH(1)) u_lock_sync (
    .clk_i (INIT_CLK),
    .rst_i (RESET),
    .d_i   (MMCM_LOCKED),
    .q_o   (lock_sync)
  );

  assign tx_ok = &tx_sync;

  always_ff @(posedge INIT_CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      mmcm_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      mmcm_reset_q <= mmcm_reset_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  // Losing any transceiver PLL overrides every per-state decision except in FLT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    loss_d     = loss_q;
    count_loss = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (tx_ok) begin
          state_d = ST_PULSE;
          cnt_d   = RST_LOAD;
        end
      end
      ST_PULSE: begin
        if (!tx_ok) begin
          state_d = ST_HOLD;
        end else if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = TIMEOUT_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_WAIT: begin
        if (!tx_ok) begin
          state_d = ST_HOLD;
        end else if (lock_sync) begin
          state_d = ST_STABLE;
          cnt_d   = STABLE_LOAD;
        end else if (cnt_q == '0) begin
          if (retry_q == RETRY_LAST) begin
            state_d = ST_FLT;
          end else begin
            state_d = ST_PULSE;
            cnt_d   = RST_LOAD;
            retry_d = retry_q + RC_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STABLE: begin
        if (!tx_ok) begin
          state_d = ST_HOLD;
        end else if (!lock_sync) begin
          state_d = ST_WAIT;
          cnt_d   = TIMEOUT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RUN: begin
        if (!tx_ok) begin
          state_d    = ST_HOLD;
          count_loss = 1'b1;
        end else if (!lock_sync) begin
          state_d    = ST_PULSE;
          cnt_d      = RST_LOAD;
          count_loss = 1'b1;
        end
      end
      ST_FLT: begin
        if (RETRY_CLR) begin
          state_d = ST_HOLD;
          retry_d = '0;
        end
      end
      default: state_d = ST_HOLD;
    endcase
    if (count_loss && (loss_q != '1)) loss_d = loss_q + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_comb begin
    mmcm_reset_d = 1'b0;
    ready_d      = 1'b0;
    fault_d      = 1'b0;
    case (state_d)
      ST_HOLD, ST_PULSE: mmcm_reset_d = 1'b1;
      ST_FLT: begin
        mmcm_reset_d = 1'b1;
        fault_d      = 1'b1;
      end
      ST_RUN:  ready_d = 1'b1;
      default: ;
    endcase
  end

  assign MMCM_RESET      = mmcm_reset_q;
  assign READY           = ready_q;
  assign MMCM_NOT_LOCKED = ~ready_q;
  assign FAULT           = fault_q;
  assign RETRY_COUNT     = retry_q;
  assign LOSS_COUNT      = loss_q;
  assign STATE           = state_q;

endmodule
